// File: rtl/alsu_pkg.sv
// Shared types for the streaming ALSU: opcode map, FSM states and the
// invalid-transaction rule used by the top-level datapath.
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR    = 3'd0,
    OP_XOR   = 3'd1,
    OP_ADD   = 3'd2,
    OP_MUL   = 3'd3,
    OP_SHIFT = 3'd4,
    OP_ROT   = 3'd5
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // Reductions only make sense for OR/XOR; codes 6 and 7 are unassigned.
  function automatic logic is_invalid(input logic red_a, input logic red_b,
                                      input logic [2:0] opcode);
    return ((red_a | red_b) & (opcode[2] | opcode[1])) |
           (opcode == 3'd6) | (opcode == 3'd7);
  endfunction

endpackage

// File: rtl/alsu_seq_mul.sv
// Radix-2 shift-add signed multiplier. One partial product per cycle for
// WIDTH cycles; the final step subtracts because the top bit of a signed
// multiplier carries negative weight. `done` and `p` are combinational and
// valid during the last step, so the caller can register p on that edge.
module alsu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] p
);

  localparam int OUT_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [OUT_W-1:0] partial;
  logic [OUT_W-1:0] acc_nxt;
  logic             last;

  // Next accumulator value for the step taken on the coming edge
  always_comb begin
    last    = (cnt == CNT_W'(1));
    partial = mplier[0] ? mcand : '0;
    acc_nxt = last ? (acc - partial) : (acc + partial);
  end

  assign done = last;
  assign p    = acc_nxt;

  // Load operands on start, then step until the down-counter reaches zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(WIDTH);
      acc    <= '0;
      mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alsu_stream.sv
// Streaming ALSU with valid/ready on both sides, one transaction in flight.
// Optional macro ALSU_FAST_MUL_EN: when defined, MUL is combinational and
// completes in one cycle like every other opcode; otherwise MUL runs on the
// sequential multiplier for WIDTH cycles in EXEC.
//
// state | meaning
// IDLE  | ready for a transaction once the held result has been drained
// EXEC  | sequential multiply in progress
module alsu_stream
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter int    FULL_ADDER     = 1,
  parameter int    LED_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  input  logic                      cin,
  input  logic [2:0]                opcode,
  input  logic                      red_op_A,
  input  logic                      red_op_B,
  input  logic                      bypass_A,
  input  logic                      bypass_B,
  input  logic                      direction,
  input  logic                      serial_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out,
  output logic                      err,
  output logic [LED_W-1:0]          leds
);

  localparam int OUT_W  = 2 * WIDTH;
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");

  state_e           state;
  state_e           state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [OUT_W-1:0] mul_p;
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic             cin_eff;
  logic             red_use_a;
  logic             red_or;
  logic             red_xor;
  logic [OUT_W-1:0] res;
  logic             res_err;
  logic             res_mul;
  logic             write_direct;
  logic             write_mul;
  logic             write_ok;

  assign a_ext   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_ext   = {{WIDTH{B[WIDTH-1]}}, B};
  assign cin_eff = (FULL_ADDER != 0) && cin;

  // Reduction operand: the priority operand wins only when both flags are set
  always_comb begin
    red_use_a = red_op_A;
    if (red_op_A && red_op_B) red_use_a = PRIO_A;
    red_or  = red_use_a ? (|A) : (|B);
    red_xor = red_use_a ? (^A) : (^B);
  end

  // Result of the presented transaction: bypass, then invalid, then opcode
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    res_mul = 1'b0;
    if (bypass_A && bypass_B) begin
      res = PRIO_A ? a_ext : b_ext;
    end else if (bypass_A) begin
      res = a_ext;
    end else if (bypass_B) begin
      res = b_ext;
    end else if (is_invalid(red_op_A, red_op_B, opcode)) begin
      res_err = 1'b1;
    end else begin
      case (opcode_e'(opcode))
        OP_OR: begin
          if (red_op_A || red_op_B) res = {{(OUT_W-1){1'b0}}, red_or};
          else                      res = a_ext | b_ext;
        end
        OP_XOR: begin
          if (red_op_A || red_op_B) res = {{(OUT_W-1){1'b0}}, red_xor};
          else                      res = a_ext ^ b_ext;
        end
        OP_ADD: res = a_ext + b_ext + {{(OUT_W-1){1'b0}}, cin_eff};
`ifdef ALSU_FAST_MUL_EN
        OP_MUL: res = a_ext * b_ext;
`else
        OP_MUL: res_mul = 1'b1;
`endif
        OP_SHIFT: res = direction ? {out[OUT_W-2:0], serial_in}
                                  : {serial_in, out[OUT_W-1:1]};
        OP_ROT:   res = direction ? {out[OUT_W-2:0], out[OUT_W-1]}
                                  : {out[0], out[OUT_W-1:1]};
        default:  res_err = 1'b1;
      endcase
    end
  end

`ifdef ALSU_FAST_MUL_EN
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`else
  alsu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .done  (mul_done),
    .p     (mul_p)
  );
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: only a sequential multiply leaves IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && res_mul) state_nxt = EXEC;
      EXEC:    if (mul_done)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake and multiplier launch
  always_comb begin
    in_ready  = (state == IDLE) && !out_valid;
    accept    = in_valid && in_ready;
    mul_start = accept && res_mul;
    write_mul = (state == EXEC) && mul_done;
  end

  assign write_direct = accept && !res_mul;
  assign write_ok     = (write_direct && !res_err) || write_mul;

  // Result register: written on completion, held until drained; out is kept
  // after draining so SHIFT/ROTATE can chain on it
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else if (write_direct) begin
      out       <= res;
      out_valid <= 1'b1;
      err       <= res_err;
    end else if (write_mul) begin
      out       <= mul_p;
      out_valid <= 1'b1;
      err       <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error blink: toggle while err is held, clear when a good result lands
  always_ff @(posedge clk) begin
    if (rst)           leds <= '0;
    else if (write_ok) leds <= '0;
    else if (err)      leds <= ~leds;
  end

endmodule

// File: tb/tb_alsu_stream.sv
// Directed and random checks of alsu_stream against an arithmetic reference.
`timescale 1ns/1ps
module tb_alsu_stream;

  localparam int WIDTH = 8;
  localparam int OUT_W = 16;
  localparam int LED_W = 16;
`ifdef ALSU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             cin = 1'b0;
  logic [2:0]       opcode = '0;
  logic             red_op_A = 1'b0;
  logic             red_op_B = 1'b0;
  logic             bypass_A = 1'b0;
  logic             bypass_B = 1'b0;
  logic             direction = 1'b0;
  logic             serial_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out;
  logic             err;
  logic [LED_W-1:0] leds;

  always #5 clk = ~clk;

  alsu_stream #(
    .WIDTH          (WIDTH),
    .INPUT_PRIORITY ("A"),
    .FULL_ADDER     (1),
    .LED_W          (LED_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .opcode    (opcode),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .direction (direction),
    .serial_in (serial_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err),
    .leds      (leds)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       c;
    logic       ra;
    logic       rb;
    logic       ba;
    logic       bb;
    logic       dir;
    logic       si;
  } txn_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_out    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                              input logic c, input logic ra, input logic rb, input logic ba,
                              input logic bb, input logic dir, input logic si);
    txn_t t;
    t.a = a; t.b = b; t.op = op; t.c = c; t.ra = ra; t.rb = rb;
    t.ba = ba; t.bb = bb; t.dir = dir; t.si = si;
    return t;
  endfunction

  // Reference: plain integer arithmetic, {err, out[15:0]}; priority operand is A
  function automatic logic [16:0] ref_op(input txn_t t, input logic [15:0] held);
    int   ai, bi, h, r, cnt;
    logic e;
    ai = $signed(t.a);
    bi = $signed(t.b);
    h  = {16'b0, held};
    e  = 1'b0;
    r  = 0;
    cnt = t.ra ? $countones(t.a) : $countones(t.b);
    if (t.ba)      r = ai;
    else if (t.bb) r = bi;
    else if (t.op > 3'd5 || ((t.ra || t.rb) && t.op > 3'd1)) e = 1'b1;
    else begin
      case (t.op)
        3'd0: r = (t.ra || t.rb) ? ((cnt != 0) ? 1 : 0) : (ai | bi);
        3'd1: r = (t.ra || t.rb) ? (cnt % 2) : (ai ^ bi);
        3'd2: r = ai + bi + (t.c ? 1 : 0);
        3'd3: r = ai * bi;
        3'd4: r = t.dir ? ((h * 2) % 65536 + (t.si ? 1 : 0)) : (h / 2 + (t.si ? 32768 : 0));
        default: r = t.dir ? ((h * 2) % 65536 + h / 32768) : (h / 2 + (h % 2) * 32768);
      endcase
    end
    return {e, r[15:0]};
  endfunction

  function automatic bit is_seq_mul(input txn_t t);
    return !t.ba && !t.bb && !t.ra && !t.rb && t.op == 3'd3;
  endfunction

  // Present one transaction, wait for its result and check it against the model
  task automatic send(input txn_t t, input string tag);
    logic [16:0] exp;
    int          waitc, lat, exp_lat;
    bit          ready_low;
    exp     = ref_op(t, m_out);
    exp_lat = is_seq_mul(t) ? MUL_LAT : 1;
    A = t.a; B = t.b; opcode = t.op; cin = t.c; red_op_A = t.ra; red_op_B = t.rb;
    bypass_A = t.ba; bypass_B = t.bb; direction = t.dir; serial_in = t.si;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    lat       = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_out"}, out, exp[15:0]);
    check({tag, "_err"}, err, exp[16]);
    check({tag, "_busy"}, {ready_low, in_ready}, 2'b10);
    if (!exp[16]) check({tag, "_leds_clr"}, leds, 0);
    m_out = exp[15:0];
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    bit   stable;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out", out, 0);
    check("reset_flags", {out_valid, err, in_ready}, 3'b001);
    check("reset_leds", leds, 0);

    // ADD with carry-in
    send(mk(8'hFB, 8'h03, 3'd2, 1, 0, 0, 0, 0, 0, 0), "add");
    check("add_const", out, 16'hFFFF);
    drain("add");

    // Sequential multiplies, including the most-negative corner
    send(mk(8'h80, 8'h80, 3'd3, 0, 0, 0, 0, 0, 0, 0), "mul_min");
    check("mul_min_const", out, 16'h4000);
    drain("mul_min");
    send(mk(8'h07, 8'hFD, 3'd3, 0, 0, 0, 0, 0, 0, 0), "mul_neg");
    check("mul_neg_const", out, 16'hFFEB);

    // Result held while consumer stalls
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out !== 16'hFFEB || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    drain("hold");

    // Reductions with both flags set, then an invalid reduction and LED blink
    send(mk(8'h07, 8'h01, 3'd1, 0, 1, 1, 0, 0, 0, 0), "red_xor");
    check("red_xor_const", out, 16'h0001);
    drain("red_xor");
    send(mk(8'h12, 8'h34, 3'd2, 0, 0, 1, 0, 0, 0, 0), "inval");
    check("inval_leds0", leds, 16'h0000);
    @(posedge clk); #1;
    check("inval_leds1", leds, 16'hFFFF);
    @(posedge clk); #1;
    check("inval_leds2", leds, 16'h0000);
    drain("inval");
    send(mk(8'h05, 8'h0A, 3'd0, 0, 0, 0, 0, 0, 0, 0), "or_after_err");
    check("or_after_err_const", {err, out}, 17'h0000F);
    drain("or_after_err");

    // Shift/rotate chaining on the held value
    send(mk(8'h01, 8'h55, 3'd0, 0, 0, 0, 1, 1, 0, 0), "preload");
    check("preload_const", out, 16'h0001);
    drain("preload");
    send(mk(8'h00, 8'h00, 3'd5, 0, 0, 0, 0, 0, 0, 0), "rot_r");
    check("rot_r_const", out, 16'h8000);
    drain("rot_r");
    send(mk(8'h00, 8'h00, 3'd4, 0, 0, 0, 0, 0, 1, 1), "shl");
    check("shl_const", out, 16'h0001);
    drain("shl");

    // Reset in the middle of a multiply while the error LEDs are blinking
    send(mk(8'h00, 8'h00, 3'd4, 0, 1, 0, 0, 0, 0, 0), "inval2");
    drain("inval2");
    A = 8'h11; B = 8'h22; opcode = 3'd3; red_op_A = 0; red_op_B = 0;
    bypass_A = 0; bypass_B = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out", out, 0);
    check("midrst_flags", {out_valid, err, in_ready}, 3'b001);
    check("midrst_leds", leds, 0);
    m_out = '0;

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      t.a   = 8'($urandom);
      t.b   = 8'($urandom);
      t.op  = 3'($urandom_range(0, 7));
      t.c   = 1'($urandom);
      t.ra  = ($urandom_range(0, 5) == 0);
      t.rb  = ($urandom_range(0, 5) == 0);
      t.ba  = ($urandom_range(0, 7) == 0);
      t.bb  = ($urandom_range(0, 7) == 0);
      t.dir = 1'($urandom);
      t.si  = 1'($urandom);
      send(t, $sformatf("rnd%0d_op%0d", i, t.op));
      drain("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
